button_debounce: RTL

Single-channel push-button debouncer with press/release one-shots for the paddle controls. It sits directly downstream of the reset synchronizer: its `rst` is driven by the synchronizer's synchronized reset output, and it feeds clean levels and single-cycle pulses to the paddle-motion and game-start logic. Each board button (player 1 up/down, player 2 up/down, start) gets one instance.

---
 rtl/button_debounce.sv | 125 ++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Single-channel push-button debouncer: 2-flop synchronizer, periodic sampling tick,
// and a 4-state stability FSM producing a clean level plus press/release one-shots.
module button_debounce #(
    parameter int unsigned TICK_CYCLES    = 1_000_000,
    parameter int unsigned STABLE_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned TW = $clog2(TICK_CYCLES);
    localparam int unsigned SW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [TW-1:0] TickMax = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressPend,
        StPressed,
        StReleasePend
    } state_e;

    state_e        state_q, state_d;
    logic          s0_q, s1_q;
    logic [TW-1:0] tcnt_q;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          tick;
    logic          last_sample;

    assign tick        = (tcnt_q == TickMax);
    // Widen before the increment so the compare cannot wrap in SW bits.
    assign last_sample = ((32'(scnt_q) + 32'd1) == STABLE_SAMPLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            tcnt_q    <= '0;
            scnt_q    <= '0;
            state_q   <= StReleased;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s0_q      <= btn_in;
            s1_q      <= s0_q;
            tcnt_q    <= tick ? '0 : tcnt_q + TW'(1);
            scnt_q    <= scnt_d;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                StReleased: begin
                    if (s1_q) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d = StPressed;
                            press_d = 1'b1;
                        end else begin
                            state_d = StPressPend;
                            scnt_d  = SW'(1);
                        end
                    end
                end
                StPressPend: begin
                    if (!s1_q) begin
                        state_d = StReleased;
                        scnt_d  = '0;
                    end else if (last_sample) begin
                        state_d = StPressed;
                        scnt_d  = '0;
                        press_d = 1'b1;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                StPressed: begin
                    if (!s1_q) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d   = StReleased;
                            release_d = 1'b1;
                        end else begin
                            state_d = StReleasePend;
                            scnt_d  = SW'(1);
                        end
                    end
                end
                StReleasePend: begin
                    if (s1_q) begin
                        state_d = StPressed;
                        scnt_d  = '0;
                    end else if (last_sample) begin
                        state_d   = StReleased;
                        scnt_d    = '0;
                        release_d = 1'b1;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                default: state_d = StReleased;
            endcase
        end
        level_d = (state_d == StPressed) || (state_d == StReleasePend);
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
